axi_master_arbiter_3to1: RTL and testbench
==========================================

Name: axi_master_arbiter_3to1

Overview:
- Downstream of the CPU top-level, which exposes three AXI3 masters: icache, dcache and uncached. This block merges them into one AXI3 master port for the SoC interconnect or memory controller.
- Read and write paths are arbitrated independently, each with round-robin priority.
- At most one read transaction and one write transaction are outstanding at any time.
- Responses are routed by the latched grant, so IDs pass through unchanged.

Parameters:
BUS_WIDTH, 4, AXI ID width on every channel
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width (wstrb width = DATA_WIDTH/8)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
Input index i: 0=icache, 1=dcache, 2=uncached. Input vectors are packed, with master i in slice i.
in_ar{id,addr,len,size,burst,lock,cache,prot}  in  3x{BUS_WIDTH,ADDR_WIDTH,4,3,2,2,4,3}  AR payload per master
in_arvalid  in  3  AR valid per master
in_arready  out  3  AR ready per master
in_r{id,data,resp,last}  out  {BUS_WIDTH,DATA_WIDTH,2,1}  R payload, broadcast to all masters
in_rvalid  out  3  R valid, only the granted master's bit can be high
in_rready  in  3  R ready per master
in_aw{id,addr,len,size,burst,lock,cache,prot}  in  3x{same widths as AR}  AW payload per master
in_awvalid  in  3  AW valid per master
in_awready  out  3  AW ready per master
in_w{id,data,strb,last}  in  3x{BUS_WIDTH,DATA_WIDTH,DATA_WIDTH/8,1}  W payload per master
in_wvalid  in  3  W valid per master
in_wready  out  3  W ready per master
in_b{id,resp}  out  {BUS_WIDTH,2}  B payload, broadcast
in_bvalid  out  3  B valid
in_bready  in  3  B ready
out_ar*/out_r*/out_aw*/out_w*/out_b*  same directions as a single AXI3 master, with the single-master widths above.

Behaviour:
Read FSM, states R_IDLE, R_ADDR, R_DATA:
- R_IDLE: if any in_arvalid is high, pick the first requester after rd_last (order 0,1,2, wrapping). Register it as rd_grant and go to R_ADDR.
- AR latency: in_arvalid at cycle N gives out_arvalid at cycle N+1.
- R_ADDR:
  - out_ar* = in_ar*[rd_grant]; out_arvalid = 1.
  - in_arready[rd_grant] = out_arready; all other in_arready bits = 0.
  - On the out_arvalid & out_arready handshake, go to R_DATA.
- R_DATA:
  - in_rvalid[rd_grant] = out_rvalid; out_rready = in_rready[rd_grant].
  - On an R handshake with rlast = 1: rd_last <= rd_grant, return to R_IDLE.
  - Earliest re-grant is the cycle after the last beat.
Write FSM, states W_IDLE, W_ADDR, W_DATA, W_RESP:
- W_IDLE: arbitrate in_awvalid with wr_last, using the same rule as reads.
- W_ADDR: forward AW exactly as reads forward AR. On handshake, go to W_DATA.
- W_DATA:
  - out_w* = in_w*[wr_grant]; out_wvalid = in_wvalid[wr_grant]; in_wready[wr_grant] = out_wready.
  - On a W handshake with wlast = 1, go to W_RESP.
- W_RESP:
  - in_bvalid[wr_grant] = out_bvalid; out_bready = in_bready[wr_grant].
  - On a B handshake: wr_last <= wr_grant, go to W_IDLE.
- W data offered before the AW handshake is held off: in_wready = 0 outside W_DATA.
General rules:
- Read and write FSMs are fully independent. The same master may hold both grants simultaneously.
- Ungranted masters see ready and valid = 0 on every channel.
- Broadcast payloads (in_r*, in_b*) are pass-throughs of the out_* payload.
- rresp and bresp (including SLVERR/DECERR) pass through unmodified.
- len is passed through; beats are counted only via rlast and wlast.
Reset (asynchronous):
- Both FSMs go to IDLE; rd_last and wr_last = 2, so master 0 wins first.
- All out_*valid, out_rready, out_bready, in_*ready and in_*valid = 0.
- Payload outputs are don't-care while valid is low.
- A reset mid-burst abandons the transaction; there is no recovery handshake.
Protocol assumptions on upstream masters:
- A granted master keeps valid and payload stable until handshake (AXI rule). Grant is never revoked before handshake.
- Combinational paths exist from out_*ready to in_*ready and from in_*ready to out_*ready. There is no combinational path from valid to ready.

Test Plan:
1. After reset, all three in_arvalid raised at cycle 0 -> grants in order 0, 1, 2. Each out_araddr equals that master's address. Each in_rvalid goes only to that master. Each grant starts the cycle after the previous rlast.
2. dcache AR with arlen=7, slave inserts rvalid gaps -> exactly 8 beats reach in_rvalid[1], rlast on beat 8. in_rvalid[0] and in_rvalid[2] stay 0 throughout.
3. Uncached write AW and W raised the same cycle, awlen=0, wstrb=4'b0011 -> out_awvalid at cycle 1. out_wvalid only after the AW handshake, with wstrb intact. bresp=2'b10 is delivered to in_bvalid[2] with in_bresp=2'b10.
4. icache 8-beat read concurrent with dcache 4-beat write -> both complete, with no stall of one path caused by the other.
5. Master 1 granted and continuously requesting, master 2 also requesting -> the next grant goes to 2 before 1 is served again (round-robin fairness).
6. Reset asserted during R_DATA beat 3 -> within the same cycle (asynchronous) out_rready = 0 and in_rvalid = 0. After release, a new AR from master 0 is granted normally.

Source files
------------

// File: rtl/axi_master_arbiter_3to1.sv
// Merges the icache, dcache and uncached AXI3 masters onto one AXI3 master port.
// Read and write paths are arbitrated round-robin and independently, one transaction each in flight.
//
// state  | meaning
// R_IDLE | no read in flight, arbitrating in_arvalid
// R_ADDR | forwarding AR of rd_grant, waiting for out_arready
// R_DATA | routing R beats to rd_grant until rlast handshake
// W_IDLE | no write in flight, arbitrating in_awvalid
// W_ADDR | forwarding AW of wr_grant, W held off
// W_DATA | routing W beats from wr_grant until wlast handshake
// W_RESP | routing B to wr_grant until handshake
module axi_master_arbiter_3to1 #(
    parameter int BUS_WIDTH  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic [3*BUS_WIDTH-1:0]          in_arid,
    input  logic [3*ADDR_WIDTH-1:0]         in_araddr,
    input  logic [11:0]                     in_arlen,
    input  logic [8:0]                      in_arsize,
    input  logic [5:0]                      in_arburst,
    input  logic [5:0]                      in_arlock,
    input  logic [11:0]                     in_arcache,
    input  logic [8:0]                      in_arprot,
    input  logic [2:0]                      in_arvalid,
    output logic [2:0]                      in_arready,

    output logic [BUS_WIDTH-1:0]            in_rid,
    output logic [DATA_WIDTH-1:0]           in_rdata,
    output logic [1:0]                      in_rresp,
    output logic                            in_rlast,
    output logic [2:0]                      in_rvalid,
    input  logic [2:0]                      in_rready,

    input  logic [3*BUS_WIDTH-1:0]          in_awid,
    input  logic [3*ADDR_WIDTH-1:0]         in_awaddr,
    input  logic [11:0]                     in_awlen,
    input  logic [8:0]                      in_awsize,
    input  logic [5:0]                      in_awburst,
    input  logic [5:0]                      in_awlock,
    input  logic [11:0]                     in_awcache,
    input  logic [8:0]                      in_awprot,
    input  logic [2:0]                      in_awvalid,
    output logic [2:0]                      in_awready,

    input  logic [3*BUS_WIDTH-1:0]          in_wid,
    input  logic [3*DATA_WIDTH-1:0]         in_wdata,
    input  logic [3*(DATA_WIDTH/8)-1:0]     in_wstrb,
    input  logic [2:0]                      in_wlast,
    input  logic [2:0]                      in_wvalid,
    output logic [2:0]                      in_wready,

    output logic [BUS_WIDTH-1:0]            in_bid,
    output logic [1:0]                      in_bresp,
    output logic [2:0]                      in_bvalid,
    input  logic [2:0]                      in_bready,

    output logic [BUS_WIDTH-1:0]            out_arid,
    output logic [ADDR_WIDTH-1:0]           out_araddr,
    output logic [3:0]                      out_arlen,
    output logic [2:0]                      out_arsize,
    output logic [1:0]                      out_arburst,
    output logic [1:0]                      out_arlock,
    output logic [3:0]                      out_arcache,
    output logic [2:0]                      out_arprot,
    output logic                            out_arvalid,
    input  logic                            out_arready,

    input  logic [BUS_WIDTH-1:0]            out_rid,
    input  logic [DATA_WIDTH-1:0]           out_rdata,
    input  logic [1:0]                      out_rresp,
    input  logic                            out_rlast,
    input  logic                            out_rvalid,
    output logic                            out_rready,

    output logic [BUS_WIDTH-1:0]            out_awid,
    output logic [ADDR_WIDTH-1:0]           out_awaddr,
    output logic [3:0]                      out_awlen,
    output logic [2:0]                      out_awsize,
    output logic [1:0]                      out_awburst,
    output logic [1:0]                      out_awlock,
    output logic [3:0]                      out_awcache,
    output logic [2:0]                      out_awprot,
    output logic                            out_awvalid,
    input  logic                            out_awready,

    output logic [BUS_WIDTH-1:0]            out_wid,
    output logic [DATA_WIDTH-1:0]           out_wdata,
    output logic [DATA_WIDTH/8-1:0]         out_wstrb,
    output logic                            out_wlast,
    output logic                            out_wvalid,
    input  logic                            out_wready,

    input  logic [BUS_WIDTH-1:0]            out_bid,
    input  logic [1:0]                      out_bresp,
    input  logic                            out_bvalid,
    output logic                            out_bready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

    rd_state_t  rd_state, rd_state_nxt;
    wr_state_t  wr_state, wr_state_nxt;
    logic [1:0] rd_grant, rd_grant_nxt, rd_last, rd_last_nxt;
    logic [1:0] wr_grant, wr_grant_nxt, wr_last, wr_last_nxt;
    int         rd_idx, wr_idx;

    // First requester after the last served master, wrapping 0,1,2.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] pick;
        case (last)
            2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
        return pick;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= R_IDLE;
            rd_grant <= 2'd0;
            rd_last  <= 2'd2;
            wr_state <= W_IDLE;
            wr_grant <= 2'd0;
            wr_last  <= 2'd2;
        end else begin
            rd_state <= rd_state_nxt;
            rd_grant <= rd_grant_nxt;
            rd_last  <= rd_last_nxt;
            wr_state <= wr_state_nxt;
            wr_grant <= wr_grant_nxt;
            wr_last  <= wr_last_nxt;
        end
    end

    always_comb begin
        rd_state_nxt = rd_state;
        rd_grant_nxt = rd_grant;
        rd_last_nxt  = rd_last;
        case (rd_state)
            R_IDLE: begin
                if (|in_arvalid) begin
                    rd_grant_nxt = rr_pick(in_arvalid, rd_last);
                    rd_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                if (out_arready) rd_state_nxt = R_DATA;
            end
            R_DATA: begin
                if (out_rvalid && in_rready[rd_grant] && out_rlast) begin
                    rd_last_nxt  = rd_grant;
                    rd_state_nxt = R_IDLE;
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_nxt = wr_state;
        wr_grant_nxt = wr_grant;
        wr_last_nxt  = wr_last;
        case (wr_state)
            W_IDLE: begin
                if (|in_awvalid) begin
                    wr_grant_nxt = rr_pick(in_awvalid, wr_last);
                    wr_state_nxt = W_ADDR;
                end
            end
            W_ADDR: begin
                if (out_awready) wr_state_nxt = W_DATA;
            end
            W_DATA: begin
                if (in_wvalid[wr_grant] && out_wready && in_wlast[wr_grant])
                    wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                if (out_bvalid && in_bready[wr_grant]) begin
                    wr_last_nxt  = wr_grant;
                    wr_state_nxt = W_IDLE;
                end
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    // Handshake steering; ungranted masters always see zeros.
    always_comb begin
        out_arvalid = 1'b0;
        in_arready  = 3'b000;
        in_rvalid   = 3'b000;
        out_rready  = 1'b0;
        case (rd_state)
            R_ADDR: begin
                out_arvalid          = 1'b1;
                in_arready[rd_grant] = out_arready;
            end
            R_DATA: begin
                in_rvalid[rd_grant] = out_rvalid;
                out_rready          = in_rready[rd_grant];
            end
            default: ;
        endcase
    end

    always_comb begin
        out_awvalid = 1'b0;
        in_awready  = 3'b000;
        out_wvalid  = 1'b0;
        in_wready   = 3'b000;
        in_bvalid   = 3'b000;
        out_bready  = 1'b0;
        case (wr_state)
            W_ADDR: begin
                out_awvalid          = 1'b1;
                in_awready[wr_grant] = out_awready;
            end
            W_DATA: begin
                out_wvalid          = in_wvalid[wr_grant];
                in_wready[wr_grant] = out_wready;
            end
            W_RESP: begin
                in_bvalid[wr_grant] = out_bvalid;
                out_bready          = in_bready[wr_grant];
            end
            default: ;
        endcase
    end

    // Payloads are muxed by the latched grant regardless of state; only valid qualifies them.
    assign rd_idx = int'(rd_grant);
    assign wr_idx = int'(wr_grant);

    assign out_arid    = in_arid[rd_idx*BUS_WIDTH +: BUS_WIDTH];
    assign out_araddr  = in_araddr[rd_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign out_arlen   = in_arlen[rd_idx*4 +: 4];
    assign out_arsize  = in_arsize[rd_idx*3 +: 3];
    assign out_arburst = in_arburst[rd_idx*2 +: 2];
    assign out_arlock  = in_arlock[rd_idx*2 +: 2];
    assign out_arcache = in_arcache[rd_idx*4 +: 4];
    assign out_arprot  = in_arprot[rd_idx*3 +: 3];

    assign out_awid    = in_awid[wr_idx*BUS_WIDTH +: BUS_WIDTH];
    assign out_awaddr  = in_awaddr[wr_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign out_awlen   = in_awlen[wr_idx*4 +: 4];
    assign out_awsize  = in_awsize[wr_idx*3 +: 3];
    assign out_awburst = in_awburst[wr_idx*2 +: 2];
    assign out_awlock  = in_awlock[wr_idx*2 +: 2];
    assign out_awcache = in_awcache[wr_idx*4 +: 4];
    assign out_awprot  = in_awprot[wr_idx*3 +: 3];

    assign out_wid     = in_wid[wr_idx*BUS_WIDTH +: BUS_WIDTH];
    assign out_wdata   = in_wdata[wr_idx*DATA_WIDTH +: DATA_WIDTH];
    assign out_wstrb   = in_wstrb[wr_idx*STRB_WIDTH +: STRB_WIDTH];
    assign out_wlast   = in_wlast[wr_grant];

    assign in_rid   = out_rid;
    assign in_rdata = out_rdata;
    assign in_rresp = out_rresp;
    assign in_rlast = out_rlast;
    assign in_bid   = out_bid;
    assign in_bresp = out_bresp;

endmodule

// File: tb/tb_axi_master_arbiter_3to1.sv
// Directed bench for axi_master_arbiter_3to1: bench plays the three masters and the slave,
// expected AR/AW transactions are queued when raised and popped as the merged port presents them.
module tb_axi_master_arbiter_3to1;
    localparam int BW = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3*BW-1:0] in_arid, in_awid, in_wid;
    logic [3*AW-1:0] in_araddr, in_awaddr;
    logic [11:0] in_arlen, in_arcache, in_awlen, in_awcache;
    logic [8:0]  in_arsize, in_arprot, in_awsize, in_awprot;
    logic [5:0]  in_arburst, in_arlock, in_awburst, in_awlock;
    logic [2:0]  in_arvalid, in_arready, in_rvalid, in_rready;
    logic [2:0]  in_awvalid, in_awready, in_wvalid, in_wready, in_wlast, in_bvalid, in_bready;
    logic [3*DW-1:0] in_wdata;
    logic [11:0] in_wstrb;
    logic [BW-1:0] in_rid, in_bid;
    logic [DW-1:0] in_rdata;
    logic [1:0]  in_rresp, in_bresp;
    logic        in_rlast;

    logic [BW-1:0] out_arid, out_rid, out_awid, out_wid, out_bid;
    logic [AW-1:0] out_araddr, out_awaddr;
    logic [3:0]  out_arlen, out_arcache, out_awlen, out_awcache, out_wstrb;
    logic [2:0]  out_arsize, out_arprot, out_awsize, out_awprot;
    logic [1:0]  out_arburst, out_arlock, out_awburst, out_awlock, out_rresp, out_bresp;
    logic [DW-1:0] out_rdata, out_wdata;
    logic out_arvalid, out_arready, out_rlast, out_rvalid, out_rready;
    logic out_awvalid, out_awready, out_wlast, out_wvalid, out_wready;
    logic out_bvalid, out_bready;

    axi_master_arbiter_3to1 #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .in_arid(in_arid), .in_araddr(in_araddr), .in_arlen(in_arlen), .in_arsize(in_arsize),
        .in_arburst(in_arburst), .in_arlock(in_arlock), .in_arcache(in_arcache), .in_arprot(in_arprot),
        .in_arvalid(in_arvalid), .in_arready(in_arready),
        .in_rid(in_rid), .in_rdata(in_rdata), .in_rresp(in_rresp), .in_rlast(in_rlast),
        .in_rvalid(in_rvalid), .in_rready(in_rready),
        .in_awid(in_awid), .in_awaddr(in_awaddr), .in_awlen(in_awlen), .in_awsize(in_awsize),
        .in_awburst(in_awburst), .in_awlock(in_awlock), .in_awcache(in_awcache), .in_awprot(in_awprot),
        .in_awvalid(in_awvalid), .in_awready(in_awready),
        .in_wid(in_wid), .in_wdata(in_wdata), .in_wstrb(in_wstrb), .in_wlast(in_wlast),
        .in_wvalid(in_wvalid), .in_wready(in_wready),
        .in_bid(in_bid), .in_bresp(in_bresp), .in_bvalid(in_bvalid), .in_bready(in_bready),
        .out_arid(out_arid), .out_araddr(out_araddr), .out_arlen(out_arlen), .out_arsize(out_arsize),
        .out_arburst(out_arburst), .out_arlock(out_arlock), .out_arcache(out_arcache), .out_arprot(out_arprot),
        .out_arvalid(out_arvalid), .out_arready(out_arready),
        .out_rid(out_rid), .out_rdata(out_rdata), .out_rresp(out_rresp), .out_rlast(out_rlast),
        .out_rvalid(out_rvalid), .out_rready(out_rready),
        .out_awid(out_awid), .out_awaddr(out_awaddr), .out_awlen(out_awlen), .out_awsize(out_awsize),
        .out_awburst(out_awburst), .out_awlock(out_awlock), .out_awcache(out_awcache), .out_awprot(out_awprot),
        .out_awvalid(out_awvalid), .out_awready(out_awready),
        .out_wid(out_wid), .out_wdata(out_wdata), .out_wstrb(out_wstrb), .out_wlast(out_wlast),
        .out_wvalid(out_wvalid), .out_wready(out_wready),
        .out_bid(out_bid), .out_bresp(out_bresp), .out_bvalid(out_bvalid), .out_bready(out_bready)
    );

    typedef struct {
        int         m;
        logic [31:0] addr;
        logic [3:0] len;
        logic [3:0] id;
        logic [3:0] strb;
        logic [1:0] resp;
    } txn_t;

    txn_t ar_q[$];
    txn_t aw_q[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic raise_ar(input int m, input logic [31:0] addr, input logic [3:0] len);
        txn_t t;
        t.m = m; t.addr = addr; t.len = len; t.id = 4'(m + 4); t.strb = 4'h0; t.resp = 2'b00;
        in_araddr[m*AW +: AW] = addr;
        in_arlen[m*4 +: 4]    = len;
        in_arid[m*BW +: BW]   = t.id;
        in_arvalid[m]         = 1'b1;
        ar_q.push_back(t);
    endtask

    task automatic raise_aw(input int m, input logic [31:0] addr, input logic [3:0] len,
                            input logic [3:0] strb, input logic [1:0] resp);
        txn_t t;
        t.m = m; t.addr = addr; t.len = len; t.id = 4'(m + 8); t.strb = strb; t.resp = resp;
        in_awaddr[m*AW +: AW] = addr;
        in_awlen[m*4 +: 4]    = len;
        in_awid[m*BW +: BW]   = t.id;
        in_awvalid[m]         = 1'b1;
        aw_q.push_back(t);
    endtask

    // Slave side of one read; abort_beat >= 0 pulses reset while that beat is on the bus.
    task automatic serve_read(input int abort_beat, input bit gaps, output int k);
        txn_t e;
        logic [31:0] d;
        k = 0;
        while (!out_arvalid && k < 20) begin @(negedge clk); k++; end
        chk("ar_wait", 64'(out_arvalid), 64'd1);
        if (!out_arvalid || ar_q.size() == 0) return;
        e = ar_q.pop_front();
        chk("araddr", 64'(out_araddr), 64'(e.addr));
        chk("arlen", 64'(out_arlen), 64'(e.len));
        chk("arid", 64'(out_arid), 64'(e.id));
        out_arready = 1'b1;
        #1;
        chk("arready_route", 64'(in_arready), 64'(1 << e.m));
        @(negedge clk);
        out_arready = 1'b0;
        in_arvalid[e.m] = 1'b0;
        for (int b = 0; b <= int'(e.len); b++) begin
            if (gaps && (b % 2 == 1)) begin
                #1;
                chk("rvalid_gap", 64'(in_rvalid), 64'd0);
                @(negedge clk);
            end
            d = 32'(32'hD000_0000 | (e.m << 8) | b);
            out_rvalid = 1'b1; out_rdata = d; out_rresp = 2'(b); out_rid = e.id;
            out_rlast = (b == int'(e.len));
            in_rready[e.m] = 1'b1;
            #1;
            if (b == abort_beat) begin
                rst = 1'b1;
                #1;
                chk("rst_out_rready", 64'(out_rready), 64'd0);
                chk("rst_in_rvalid", 64'(in_rvalid), 64'd0);
                @(negedge clk);
                rst = 1'b0; out_rvalid = 1'b0; in_rready = 3'b000;
                return;
            end
            chk("rvalid_route", 64'(in_rvalid), 64'(1 << e.m));
            chk("rdata", 64'(in_rdata), 64'(d));
            chk("rresp", 64'(in_rresp), 64'(b % 4));
            chk("rlast", 64'(in_rlast), 64'(b == int'(e.len)));
            chk("rid", 64'(in_rid), 64'(e.id));
            chk("out_rready", 64'(out_rready), 64'd1);
            chk("arready_idle", 64'(in_arready), 64'd0);
            @(negedge clk);
            out_rvalid = 1'b0; in_rready[e.m] = 1'b0;
        end
    endtask

    task automatic drive_w(input int m, input int b, input txn_t e);
        in_wvalid[m]            = 1'b1;
        in_wdata[m*DW +: DW]    = 32'(32'hA000_0000 | (m << 8) | b);
        in_wstrb[m*4 +: 4]      = e.strb;
        in_wlast[m]             = (b == int'(e.len));
        in_wid[m*BW +: BW]      = e.id;
    endtask

    // Slave side of one write; w_early offers W beat 0 in the same cycle AW is raised.
    task automatic serve_write(input bit w_early, output int k);
        txn_t e;
        k = 0;
        if (w_early && aw_q.size() != 0) drive_w(aw_q[0].m, 0, aw_q[0]);
        while (!out_awvalid && k < 20) begin @(negedge clk); k++; end
        chk("aw_wait", 64'(out_awvalid), 64'd1);
        if (!out_awvalid || aw_q.size() == 0) return;
        e = aw_q.pop_front();
        chk("awaddr", 64'(out_awaddr), 64'(e.addr));
        chk("awlen", 64'(out_awlen), 64'(e.len));
        chk("awid", 64'(out_awid), 64'(e.id));
        out_wready = 1'b1;
        #1;
        chk("w_hold_wready", 64'(in_wready), 64'd0);
        chk("w_hold_wvalid", 64'(out_wvalid), 64'd0);
        out_awready = 1'b1;
        #1;
        chk("awready_route", 64'(in_awready), 64'(1 << e.m));
        @(negedge clk);
        out_awready = 1'b0;
        in_awvalid[e.m] = 1'b0;
        for (int b = 0; b <= int'(e.len); b++) begin
            drive_w(e.m, b, e);
            out_wready = 1'b1;
            #1;
            chk("out_wvalid", 64'(out_wvalid), 64'd1);
            chk("wdata", 64'(out_wdata), 64'(32'hA000_0000 | (e.m << 8) | b));
            chk("wstrb", 64'(out_wstrb), 64'(e.strb));
            chk("wlast", 64'(out_wlast), 64'(b == int'(e.len)));
            chk("wready_route", 64'(in_wready), 64'(1 << e.m));
            @(negedge clk);
            in_wvalid[e.m] = 1'b0;
            out_wready = 1'b0;
        end
        out_bvalid = 1'b1; out_bresp = e.resp; out_bid = e.id;
        in_bready[e.m] = 1'b1;
        #1;
        chk("bvalid_route", 64'(in_bvalid), 64'(1 << e.m));
        chk("bresp", 64'(in_bresp), 64'(e.resp));
        chk("bid", 64'(in_bid), 64'(e.id));
        chk("out_bready", 64'(out_bready), 64'd1);
        @(negedge clk);
        out_bvalid = 1'b0; in_bready[e.m] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int k, k1, k2;
        rst = 1'b1;
        in_arid = '0; in_araddr = '0; in_arlen = '0; in_arsize = '0; in_arburst = '0;
        in_arlock = '0; in_arcache = '0; in_arprot = '0;
        in_awid = '0; in_awaddr = '0; in_awlen = '0; in_awsize = '0; in_awburst = '0;
        in_awlock = '0; in_awcache = '0; in_awprot = '0;
        in_wid = '0; in_wdata = '0; in_wstrb = '0; in_wlast = '0;
        out_rid = '0; out_rdata = '0; out_rresp = '0; out_rlast = 1'b0;
        out_bid = '0; out_bresp = '0;
        // Everything upstream and downstream active during reset: outputs must still be quiet.
        in_arvalid = 3'b111; in_awvalid = 3'b111; in_wvalid = 3'b111;
        in_rready = 3'b111; in_bready = 3'b111;
        out_arready = 1'b1; out_awready = 1'b1; out_wready = 1'b1;
        out_rvalid = 1'b1; out_bvalid = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_arvalid", 64'(out_arvalid), 64'd0);
        chk("rst_awvalid", 64'(out_awvalid), 64'd0);
        chk("rst_wvalid", 64'(out_wvalid), 64'd0);
        chk("rst_rready", 64'(out_rready), 64'd0);
        chk("rst_bready", 64'(out_bready), 64'd0);
        chk("rst_in_ready", 64'({in_arready, in_awready, in_wready}), 64'd0);
        chk("rst_in_valid", 64'({in_rvalid, in_bvalid}), 64'd0);
        rst = 1'b0;
        in_arvalid = '0; in_awvalid = '0; in_wvalid = '0; in_rready = '0; in_bready = '0;
        out_arready = 1'b0; out_awready = 1'b0; out_wready = 1'b0;
        out_rvalid = 1'b0; out_bvalid = 1'b0;
        @(negedge clk);

        // All three request together: served 0,1,2, each re-grant one cycle after rlast.
        raise_ar(0, 32'h0000_1000, 4'd1);
        raise_ar(1, 32'h0000_2000, 4'd1);
        raise_ar(2, 32'h0000_3000, 4'd1);
        serve_read(-1, 1'b0, k); chk("ar_latency_m0", 64'(k), 64'd1);
        serve_read(-1, 1'b0, k); chk("regrant_m1", 64'(k), 64'd1);
        serve_read(-1, 1'b0, k); chk("regrant_m2", 64'(k), 64'd1);

        // dcache 8-beat burst with rvalid gaps.
        raise_ar(1, 32'h0000_4000, 4'd7);
        serve_read(-1, 1'b1, k); chk("ar_latency_m1", 64'(k), 64'd1);

        // Master 1 just served and asks again alongside master 2: 2 must go first.
        raise_ar(2, 32'h0000_5000, 4'd0);
        raise_ar(1, 32'h0000_6000, 4'd0);
        serve_read(-1, 1'b0, k);
        serve_read(-1, 1'b0, k);

        // Uncached single-beat write with W offered alongside AW, SLVERR response.
        raise_aw(2, 32'h0000_7000, 4'd0, 4'b0011, 2'b10);
        serve_write(1'b1, k); chk("aw_latency_m2", 64'(k), 64'd1);

        // Concurrent icache read and dcache write.
        raise_ar(0, 32'h0000_8000, 4'd7);
        raise_aw(1, 32'h0000_9000, 4'd3, 4'b1111, 2'b00);
        fork
            serve_read(-1, 1'b0, k1);
            serve_write(1'b0, k2);
        join
        chk("conc_rd_latency", 64'(k1), 64'd1);
        chk("conc_wr_latency", 64'(k2), 64'd1);

        // Reset during beat 3 of an 8-beat read, then a fresh read.
        raise_ar(0, 32'h0000_A000, 4'd7);
        serve_read(3, 1'b0, k);
        chk("post_rst_arvalid", 64'(out_arvalid), 64'd0);
        raise_ar(0, 32'h0000_B000, 4'd1);
        serve_read(-1, 1'b0, k); chk("post_rst_latency", 64'(k), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
